// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer for an up/down counter: lo -> hi -> lo, n times, then done.
// Optional SWEEP_PAUSE_EN adds a 'pause' input that freezes the sweep in UP/DOWN.
//
// state | meaning
// IDLE  | waiting for start; limits checked on start
// LOAD  | one-cycle counter load with the latched lower bound
// UP    | counting towards hi, one dwell cycle at the peak
// DOWN  | counting towards lo, one dwell cycle at the floor, sweep counted
// DONE  | one-cycle completion pulse
module updown_sweep_ctrl #(
   parameter int WIDTH   = 4,
   parameter int SWEEP_W = 4
) (
   input  logic               Clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   lo_lim,
   input  logic [WIDTH-1:0]   hi_lim,
   input  logic [SWEEP_W-1:0] n_sweeps,
   input  logic               abort,
`ifdef SWEEP_PAUSE_EN
   input  logic               pause,
`endif
   input  logic [WIDTH-1:0]   Count,
   output logic               UpOrDown,
   output logic               cnt_en,
   output logic               cnt_load,
   output logic [WIDTH-1:0]   load_val,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [SWEEP_W-1:0] sweep_cnt
);

   typedef enum logic [2:0] {IDLE, LOAD, UP, DOWN, DONE} state_t;

   state_t             state;
   logic [WIDTH-1:0]   lo;
   logic [WIDTH-1:0]   hi;
   logic [SWEEP_W-1:0] n;
   logic [SWEEP_W-1:0] sweep_nxt;
   logic               hold;

`ifdef SWEEP_PAUSE_EN
   assign hold = pause;
`else
   assign hold = 1'b0;
`endif

   assign sweep_nxt = sweep_cnt + 1'b1;

   // Enable is combinational on Count so the counter stops exactly at the bound.
   always_comb begin
      cnt_en = 1'b0;
      case (state)
         UP:      cnt_en = (Count != hi) && !abort && !hold;
         DOWN:    cnt_en = (Count != lo) && !abort && !hold;
         default: cnt_en = 1'b0;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         state     <= IDLE;
         lo        <= '0;
         hi        <= '0;
         n         <= '0;
         UpOrDown  <= 1'b0;
         cnt_load  <= 1'b0;
         load_val  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         sweep_cnt <= '0;
      end else begin
         cnt_load <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (lo_lim >= hi_lim || n_sweeps == '0) begin
                     err <= 1'b1;
                  end else begin
                     lo        <= lo_lim;
                     hi        <= hi_lim;
                     n         <= n_sweeps;
                     sweep_cnt <= '0;
                     load_val  <= lo_lim;
                     cnt_load  <= 1'b1;
                     busy      <= 1'b1;
                     state     <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  UpOrDown <= 1'b1;
                  state    <= UP;
               end
            end
            UP: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (!hold && Count == hi) begin
                  UpOrDown <= 1'b0;
                  state    <= DOWN;
               end
            end
            DOWN: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (!hold && Count == lo) begin
                  sweep_cnt <= sweep_nxt;
                  if (sweep_nxt == n) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     UpOrDown <= 1'b1;
                     state    <= UP;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
